// File: rtl/crc_pkg.sv
// Shared definitions for the streaming CRC peripheral: register map,
// CONF/STATUS bit positions, engine states, reset defaults and bus helpers.
package crc_pkg;

    localparam logic [3:0] OFF_DATA   = 4'd0;
    localparam logic [3:0] OFF_DATA8  = 4'd1;
    localparam logic [3:0] OFF_CONF   = 4'd2;
    localparam logic [3:0] OFF_POLY   = 4'd3;
    localparam logic [3:0] OFF_INIT   = 4'd4;
    localparam logic [3:0] OFF_XOROUT = 4'd5;
    localparam logic [3:0] OFF_RESULT = 4'd6;
    localparam logic [3:0] OFF_COUNT  = 4'd7;
    localparam logic [3:0] OFF_STATUS = 4'd8;

    localparam int CONF_RESTART   = 0;
    localparam int CONF_REFIN     = 1;
    localparam int CONF_REFOUT    = 2;
    localparam int CONF_LSB_FIRST = 3;

    localparam int ST_BUSY = 0;
    localparam int ST_FULL = 1;
    localparam int ST_OVF  = 2;

    localparam logic [31:0] POLY_RST   = 32'h04C1_1DB7;
    localparam logic [31:0] INIT_RST   = 32'hFFFF_FFFF;
    localparam logic [31:0] XOROUT_RST = 32'h0000_0000;

    typedef enum logic {IDLE, SHIFT} state_e;

    // Bytes are left-justified in processing order; n is the valid byte count.
    typedef struct packed {
        logic [31:0] bytes;
        logic [2:0]  n;
    } fifo_entry_t;

    function automatic logic [31:0] merge_halves(input logic [31:0] cur, input logic [31:0] src,
                                                 input logic wr_l, input logic wr_h);
        return {wr_h ? src[31:16] : cur[31:16], wr_l ? src[15:0] : cur[15:0]};
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

endpackage

// File: rtl/crc_stream_engine_step.sv
// Folds one byte into an MSB-first CRC register of width CRC_W.
module crc_byte_step #(
    parameter int CRC_W = 32
) (
    input  logic [CRC_W-1:0] crc_i,
    input  logic [7:0]       byte_i,
    input  logic [CRC_W-1:0] poly_i,
    output logic [CRC_W-1:0] crc_o
);

    logic [CRC_W-1:0] acc;

    // NOTE: combinational blocks use blocking '=' so each loop pass sees the
    // previous pass; clocked state elsewhere is only ever assigned with '<='.
    always_comb begin
        acc = crc_i ^ (CRC_W'(byte_i) << (CRC_W - 8));
        for (int i = 0; i < 8; i++) begin
            acc = acc[CRC_W-1] ? ((acc << 1) ^ poly_i) : (acc << 1);
        end
        crc_o = acc;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Memory-mapped CRC peripheral: bus pushes land in a small FIFO that a
// byte-serial engine drains at one byte per clock.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int PAW        = 10,
    parameter int BASE_ADR   = 'h2B0,
    parameter int CRC_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           edwr_l_i,
    input  logic           edwr_h_i,
    input  logic           sedrd_i,
    input  logic [PAW-1:0] pr_adr_i,
    input  logic [31:0]    src_i,
    output logic [31:0]    pr_src_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [PAW-1:0] off;
    logic [3:0]     reg_off;
    logic           hit, wr_l, wr_h, restart;

    logic [CRC_W-1:0] poly_q, poly_d, init_q, init_d, xorout_q, xorout_d;
    logic [CRC_W-1:0] crc_q, crc_d, crc_rev, step_crc, result;
    logic [CONF_LSB_FIRST:CONF_REFIN] conf_q, conf_d;
    logic [31:0]      count_q, count_d, rdata;
    logic             ovf_q, ovf_d, ovf_set;

    fifo_entry_t      fifo_mem [FIFO_DEPTH];
    fifo_entry_t      push_entry, head;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full, empty, busy, push_req, push_ok, pop, fold;

    state_e           state_q, state_d;
    logic [31:0]      sh_q, sh_d;
    logic [2:0]       rem_q, rem_d;
    logic [7:0]       step_byte;

    // Offset wraps for addresses below the base, so one compare covers both ends.
    assign off     = pr_adr_i - PAW'(BASE_ADR);
    assign hit     = (off <= PAW'(OFF_STATUS));
    assign reg_off = off[3:0];
    assign wr_l    = hit && !edwr_l_i;
    assign wr_h    = hit && !edwr_h_i;
    assign restart = wr_l && (reg_off == OFF_CONF) && src_i[CONF_RESTART];

    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign busy  = (state_q != IDLE) || !empty;
    assign head  = fifo_mem[rd_ptr_q];

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        poly_d   = poly_q;
        init_d   = init_q;
        xorout_d = xorout_q;
        conf_d   = conf_q;
        case (reg_off)
            OFF_POLY:   poly_d   = CRC_W'(merge_halves(32'(poly_q), src_i, wr_l, wr_h));
            OFF_INIT:   init_d   = CRC_W'(merge_halves(32'(init_q), src_i, wr_l, wr_h));
            OFF_XOROUT: xorout_d = CRC_W'(merge_halves(32'(xorout_q), src_i, wr_l, wr_h));
            OFF_CONF:   if (wr_l) conf_d = src_i[CONF_LSB_FIRST:CONF_REFIN];
            default: ;
        endcase
    end

    always_comb begin
        push_req   = 1'b0;
        push_entry = '0;
        if (!restart) begin
            if ((reg_off == OFF_DATA) && (wr_l || wr_h)) begin
                push_req = 1'b1;
                if (wr_l && wr_h) begin
                    push_entry.n     = 3'd4;
                    push_entry.bytes = conf_q[CONF_LSB_FIRST]
                                     ? {src_i[7:0], src_i[15:8], src_i[23:16], src_i[31:24]}
                                     : src_i;
                end else if (wr_l) begin
                    push_entry.n     = 3'd2;
                    push_entry.bytes = conf_q[CONF_LSB_FIRST]
                                     ? {src_i[7:0], src_i[15:8], 16'h0}
                                     : {src_i[15:0], 16'h0};
                end else begin
                    push_entry.n     = 3'd2;
                    push_entry.bytes = conf_q[CONF_LSB_FIRST]
                                     ? {src_i[23:16], src_i[31:24], 16'h0}
                                     : {src_i[31:16], 16'h0};
                end
            end else if ((reg_off == OFF_DATA8) && wr_l) begin
                push_req         = 1'b1;
                push_entry.n     = 3'd1;
                push_entry.bytes = {src_i[7:0], 24'h0};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        fold    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = head.bytes;
                    rem_d   = head.n;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                fold  = 1'b1;
                sh_d  = sh_q << 8;
                rem_d = rem_q - 3'd1;
                if (rem_q == 3'd1) begin
                    if (!empty) begin
                        pop   = 1'b1;
                        sh_d  = head.bytes;
                        rem_d = head.n;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (restart) begin
            state_d = IDLE;
            pop     = 1'b0;
            fold    = 1'b0;
        end
    end

    assign push_ok = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        crc_d    = crc_q;
        count_d  = count_q;
        ovf_d    = ovf_q || ovf_set;
        if (restart) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            crc_d    = init_d;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok && !pop)      level_d = level_q + LW'(1);
            else if (pop && !push_ok) level_d = level_q - LW'(1);
            if (fold) begin
                crc_d   = step_crc;
                count_d = count_q + 32'd1;
            end
        end
    end

    assign step_byte = conf_q[CONF_REFIN] ? rev8(sh_q[31:24]) : sh_q[31:24];

    crc_byte_step #(.CRC_W(CRC_W)) u_step (
        .crc_i  (crc_q),
        .byte_i (step_byte),
        .poly_i (poly_q),
        .crc_o  (step_crc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            poly_q   <= CRC_W'(POLY_RST);
            init_q   <= CRC_W'(INIT_RST);
            xorout_q <= CRC_W'(XOROUT_RST);
            conf_q   <= '0;
            crc_q    <= CRC_W'(INIT_RST);
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            sh_q     <= '0;
            rem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            poly_q   <= poly_d;
            init_q   <= init_d;
            xorout_q <= xorout_d;
            conf_q   <= conf_d;
            crc_q    <= crc_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            sh_q     <= sh_d;
            rem_q    <= rem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers and level alone define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= push_entry;
    end

    always_comb begin
        crc_rev = '0;
        for (int i = 0; i < CRC_W; i++) crc_rev[i] = crc_q[CRC_W-1-i];
    end

    assign result = (conf_q[CONF_REFOUT] ? crc_rev : crc_q) ^ xorout_q;

    always_comb begin
        rdata = '0;
        case (reg_off)
            OFF_CONF:   rdata = {28'd0, conf_q, 1'b0};
            OFF_POLY:   rdata = 32'(poly_q);
            OFF_INIT:   rdata = 32'(init_q);
            OFF_XOROUT: rdata = 32'(xorout_q);
            OFF_RESULT: rdata = 32'(result);
            OFF_COUNT:  rdata = count_q;
            OFF_STATUS: rdata = {23'd0, 5'(level_q), 1'b0, ovf_q, full, busy};
            default:    rdata = '0;
        endcase
    end

    assign pr_src_o = (hit && !sedrd_i) ? rdata : 'z;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench: a CRC-32 and a CRC-8 instance on one bus at different bases,
// checked against well-known CRC catalogue values and hand-traced timing.
module tb_crc_stream_engine;

    localparam logic [9:0] B32 = 10'h2B0;
    localparam logic [9:0] B8  = 10'h300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        edwr_l = 1'b1;
    logic        edwr_h = 1'b1;
    logic        sedrd = 1'b1;
    logic [9:0]  pr_adr = '0;
    logic [31:0] src = '0;
    wire  [31:0] rd32;
    wire  [31:0] rd8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crc_stream_engine #(.PAW(10), .BASE_ADR('h2B0), .CRC_W(32), .FIFO_DEPTH(4)) dut32 (
        .clk_i(clk), .rst_i(rst), .edwr_l_i(edwr_l), .edwr_h_i(edwr_h), .sedrd_i(sedrd),
        .pr_adr_i(pr_adr), .src_i(src), .pr_src_o(rd32)
    );

    crc_stream_engine #(.PAW(10), .BASE_ADR('h300), .CRC_W(8), .FIFO_DEPTH(4)) dut8 (
        .clk_i(clk), .rst_i(rst), .edwr_l_i(edwr_l), .edwr_h_i(edwr_h), .sedrd_i(sedrd),
        .pr_adr_i(pr_adr), .src_i(src), .pr_src_o(rd8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every task starts and ends on a falling edge: one bus cycle each.
    task automatic wr(input logic [9:0] adr, input logic [31:0] d, input logic l, input logic h);
        pr_adr = adr;
        src    = d;
        edwr_l = ~l;
        edwr_h = ~h;
        @(negedge clk);
        edwr_l = 1'b1;
        edwr_h = 1'b1;
    endtask

    task automatic rd(input logic [9:0] adr, output logic [31:0] v);
        pr_adr = adr;
        sedrd  = 1'b0;
        #1;
        v      = (adr >= B8) ? rd8 : rd32;
        sedrd  = 1'b1;
        @(negedge clk);
    endtask

    task automatic expect_rd(input string tag, input logic [9:0] adr, input logic [31:0] exp);
        logic [31:0] v;
        rd(adr, v);
        check(tag, v, exp);
    endtask

    task automatic wait_idle(input string tag, input logic [9:0] base);
        logic [31:0] v;
        for (int i = 0; i < 200; i++) begin
            rd(base + 10'd8, v);
            if (!v[0]) break;
        end
        check(tag, {31'd0, v[0]}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        expect_rd("rst_poly",   B32 + 10'd3, 32'h04C11DB7);
        expect_rd("rst_init",   B32 + 10'd4, 32'hFFFFFFFF);
        expect_rd("rst_xorout", B32 + 10'd5, 32'h00000000);
        expect_rd("rst_conf",   B32 + 10'd2, 32'h00000000);
        expect_rd("rst_result", B32 + 10'd6, 32'hFFFFFFFF);
        expect_rd("rst_count",  B32 + 10'd7, 32'h00000000);
        expect_rd("rst_status", B32 + 10'd8, 32'h00000000);
        expect_rd("rst8_poly",  B8 + 10'd3,  32'h000000B7);

        // CRC-32/MPEG-2, first word also traced cycle by cycle.
        wr(B32 + 10'd2, 32'h1, 1'b1, 1'b0);
        wr(B32 + 10'd0, 32'h31323334, 1'b1, 1'b1);
        expect_rd("lat_status_T",  B32 + 10'd8, 32'h00000011);
        expect_rd("lat_count_T1",  B32 + 10'd7, 32'd0);
        expect_rd("lat_count_T2",  B32 + 10'd7, 32'd1);
        expect_rd("lat_count_T3",  B32 + 10'd7, 32'd2);
        expect_rd("lat_status_T4", B32 + 10'd8, 32'h00000001);
        expect_rd("lat_status_T5", B32 + 10'd8, 32'h00000000);
        expect_rd("lat_count_T6",  B32 + 10'd7, 32'd4);
        wr(B32 + 10'd0, 32'h35363738, 1'b1, 1'b1);
        wr(B32 + 10'd1, 32'h00000039, 1'b1, 1'b0);
        wait_idle("mpeg2_idle", B32);
        expect_rd("mpeg2_result", B32 + 10'd6, 32'h0376E6E7);
        expect_rd("mpeg2_count",  B32 + 10'd7, 32'd9);

        // CRC-32 (reflected), bytes pushed LSB-first.
        wr(B32 + 10'd3, 32'h04C11DB7, 1'b1, 1'b1);
        wr(B32 + 10'd4, 32'hFFFFFFFF, 1'b1, 1'b1);
        wr(B32 + 10'd5, 32'hFFFFFFFF, 1'b1, 1'b1);
        wr(B32 + 10'd2, 32'h0000000F, 1'b1, 1'b0);
        expect_rd("crc32_conf",    B32 + 10'd2, 32'h0000000E);
        expect_rd("crc32_xorout",  B32 + 10'd5, 32'hFFFFFFFF);
        expect_rd("crc32_res0",    B32 + 10'd6, 32'h00000000);
        wr(B32 + 10'd0, 32'h34333231, 1'b1, 1'b1);
        wr(B32 + 10'd0, 32'h38373635, 1'b1, 1'b1);
        wr(B32 + 10'd1, 32'h00000039, 1'b1, 1'b0);
        wait_idle("crc32_idle", B32);
        expect_rd("crc32_result", B32 + 10'd6, 32'hCBF43926);
        expect_rd("crc32_count",  B32 + 10'd7, 32'd9);

        // CRC-32Q with half-word writes and half-word pushes.
        wr(B32 + 10'd3, 32'h81410000, 1'b0, 1'b1);
        wr(B32 + 10'd3, 32'h000041AB, 1'b1, 1'b0);
        expect_rd("q_poly", B32 + 10'd3, 32'h814141AB);
        wr(B32 + 10'd4, 32'h00000000, 1'b1, 1'b1);
        wr(B32 + 10'd5, 32'h00000000, 1'b1, 1'b1);
        wr(B32 + 10'd2, 32'h00000001, 1'b1, 1'b0);
        expect_rd("q_res0", B32 + 10'd6, 32'h00000000);
        wr(B32 + 10'd0, 32'h3132FFFF, 1'b0, 1'b1);
        wr(B32 + 10'd0, 32'hFFFF3334, 1'b1, 1'b0);
        wr(B32 + 10'd0, 32'h35363738, 1'b1, 1'b1);
        wr(B32 + 10'd1, 32'h00000039, 1'b1, 1'b0);
        wait_idle("q_idle", B32);
        expect_rd("q_result", B32 + 10'd6, 32'h3010BF7F);
        expect_rd("q_count",  B32 + 10'd7, 32'd9);

        // CRC-8 instance.
        wr(B8 + 10'd3, 32'hFFFFFF07, 1'b1, 1'b1);
        expect_rd("c8_poly", B8 + 10'd3, 32'h00000007);
        wr(B8 + 10'd4, 32'h00000000, 1'b1, 1'b1);
        wr(B8 + 10'd2, 32'h00000001, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) wr(B8 + 10'd1, 32'h31 + i, 1'b1, 1'b0);
        wait_idle("c8_idle", B8);
        expect_rd("c8_result", B8 + 10'd6, 32'h000000F4);
        expect_rd("c8_count",  B8 + 10'd7, 32'd9);

        // Overflow: pushes at T..T+7; T+5 push meets a pop, T+6 and T+7 drop.
        wr(B32 + 10'd2, 32'h00000001, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) wr(B32 + 10'd0, 32'hA5000000 + i, 1'b1, 1'b1);
        expect_rd("ovf_status_full", B32 + 10'd8, 32'h00000047);
        wait_idle("ovf_idle", B32);
        expect_rd("ovf_status", B32 + 10'd8, 32'h00000004);
        expect_rd("ovf_count",  B32 + 10'd7, 32'd24);
        wr(B32 + 10'd2, 32'h00000001, 1'b1, 1'b0);
        expect_rd("ovf_clr_status", B32 + 10'd8, 32'h00000000);
        expect_rd("ovf_clr_count",  B32 + 10'd7, 32'd0);
        expect_rd("ovf_clr_result", B32 + 10'd6, 32'h00000000);

        // RESTART while shifting with a queued entry: everything is discarded.
        wr(B32 + 10'd0, 32'h11223344, 1'b1, 1'b1);
        wr(B32 + 10'd0, 32'h55667788, 1'b1, 1'b1);
        wr(B32 + 10'd2, 32'h00000001, 1'b1, 1'b0);
        expect_rd("abort_status", B32 + 10'd8, 32'h00000000);
        expect_rd("abort_count",  B32 + 10'd7, 32'd0);
        expect_rd("abort_count2", B32 + 10'd7, 32'd0);

        // Reset while the second byte of a word is being folded.
        wr(B32 + 10'd0, 32'hDEADBEEF, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_rd("mid_rst_result", B32 + 10'd6, 32'hFFFFFFFF);
        expect_rd("mid_rst_count",  B32 + 10'd7, 32'd0);
        expect_rd("mid_rst_status", B32 + 10'd8, 32'h00000000);
        expect_rd("mid_rst_poly",   B32 + 10'd3, 32'h04C11DB7);
        expect_rd("mid_rst_conf",   B32 + 10'd2, 32'h00000000);
        expect_rd("mid_rst8_res",   B8 + 10'd6,  32'h000000FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
